nzcv_flag_pipe: RTL
===================

// Module: nzcv_flag_pipe
// PURPOSE
//  Consumes the 64-bit subtract/compare result of the EX-stage subtractor (result, overflow, cout), derives
//  NZCV, carries it through a 1-entry EX/MEM flag register, commits it to the architectural flag register,
//  and evaluates B.cond conditions against the youngest flags, forwarding from the in-flight entry.
// PARAMETERS
//  WIDTH   64  operand/result width; N = ex_result[WIDTH-1]
// PORTS
//  clk            in   1      single clock; all state changes on posedge
//  reset          in   1      synchronous, active-high
//  ex_valid       in   1      EX stage holds a live instruction
//  ex_set_flags   in   1      instruction writes flags (SUBS/CMP)
//  ex_result      in   WIDTH  subtractor sum
//  ex_overflow    in   1      subtractor signed overflow (V)
//  ex_cout        in   1      subtractor carry out (C; 1 = no borrow)
//  stall          in   1      freeze pipe registers this cycle
//  flush          in   1      kill the in-flight (uncommitted) flag entry
//  cond_valid     in   1      consumer requests a condition evaluation
//  cond_code      in   4      ARM condition field
//  cond_taken     out  1      condition result (comb); meaningful only when cond_valid && !cond_hold
//  cond_hold      out  1      consumer must retry next cycle (flags not yet resolvable)
//  flags_arch     out  4      committed {N,Z,C,V}
//  flags_pending  out  1      EX/MEM flag entry valid
// BEHAVIOUR
//  - Reset (sync, highest priority): pend_v=0, pend_f=0000, flags_arch=0000; cond_hold=0; cond_taken=0 when !cond_valid.
//  - Flag derive (comb): N=ex_result[WIDTH-1], Z=(ex_result==0), C=ex_cout, V=ex_overflow.
//  - Capture: if !stall && !flush && ex_valid && ex_set_flags -> pend_v<=1, pend_f<=derived. If !stall && none -> pend_v<=0.
//  - Commit: if !stall && pend_v -> flags_arch<=pend_f same edge as capture. Latency EX->flags_arch = 2 edges.
//  - Flush: pend_v<=0 and pend_f not committed on that edge; flags_arch unchanged; flush beats stall; a
//    concurrent EX producer is also killed (not captured).
//  - Stall (no flush): pend_v, pend_f, flags_arch all hold.
//  - Eval flags: pend_v ? pend_f : flags_arch (forwarding, see CONFIGURATION).
//  - cond_hold = cond_valid && ex_valid && ex_set_flags (producer in EX same cycle; one-cycle interlock).
//  - Conditions: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z;
//    9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 1 (ARMv8: always).
//  - cond_taken=0 whenever cond_valid=0 or cond_hold=1.
//  - Back-to-back producers: each edge the older entry commits and the newer replaces it; no flag update lost.
//  - Reset mid-operation discards pending entry; no commit.
// CONFIGURATION
//  FLAG_FWD_EN defined: eval flags forwarded from pend_f when pend_v (as above).
//  FLAG_FWD_EN undefined: no forwarding; eval flags = flags_arch only and cond_hold additionally
//    asserts when cond_valid && pend_v (two-cycle interlock after a producer). Pipe timing otherwise identical.
// STRUCTURE
//  Package arm_flags_pkg: typedef struct packed {N,Z,C,V} nzcv_t; typedef enum logic[3:0] cond_e (EQ..NV);
//    function/constant NZCV_RESET = 4'b0000.
//  Sub-module cond_eval (comb): nzcv_t flags, cond_e code -> taken. Top holds registers, hazard and bypass mux.
// TESTING
//  1 res=0, cout=1, ovf=0, set_flags -> pend_f=0110 after edge 1; flags_arch=0110 after edge 2; EQ next cycle
//    taken via forward (FLAG_FWD_EN), hold=1 then taken=1 without it.
//  2 res=64'h7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1 (0x8000..0-1) -> NZCV=0011; VS taken, GE not taken, LT taken.
//  3 producer 1000 captured, flush next cycle -> pend_v=0, flags_arch keeps prior 0110; MI not taken.
//  4 producer captured, stall 3 cycles -> flags_arch unchanged throughout, commits on first unstalled edge.
//  5 cond_valid with ex_set_flags same cycle -> cond_hold=1, cond_taken=0; next cycle resolves correctly.
//  6 back-to-back producers 0110 then 1000, reset asserted after first edge -> all state 0000, pend_v=0, no commit.

Source files
------------

// File: rtl/arm_flags_pkg.sv
// Shared NZCV flag types and ARM condition encodings.
// Used by nzcv_flag_pipe and cond_eval.
package arm_flags_pkg;

  typedef struct packed {
    logic N;
    logic Z;
    logic C;
    logic V;
  } nzcv_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  localparam nzcv_t NZCV_RESET = 4'b0000;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator.
// Ports: flags (nzcv_t in), code (cond_e in), taken (out).
module cond_eval
  import arm_flags_pkg::*;
(
  input  nzcv_t flags,
  input  cond_e code,
  output logic  taken
);

  logic ge;
  assign ge = (flags.N == flags.V);

  always_comb begin
    taken = 1'b0;
    unique case (code)
      COND_EQ: taken = flags.Z;
      COND_NE: taken = !flags.Z;
      COND_CS: taken = flags.C;
      COND_CC: taken = !flags.C;
      COND_MI: taken = flags.N;
      COND_PL: taken = !flags.N;
      COND_VS: taken = flags.V;
      COND_VC: taken = !flags.V;
      COND_HI: taken = flags.C && !flags.Z;
      COND_LS: taken = !flags.C || flags.Z;
      COND_GE: taken = ge;
      COND_LT: taken = !ge;
      COND_GT: taken = !flags.Z && ge;
      COND_LE: taken = flags.Z || !ge;
      // NV behaves as always in ARMv8
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/nzcv_flag_pipe.sv
// NZCV derive, EX/MEM flag entry, architectural commit and B.cond eval.
// Ports: clk, reset (sync high), ex_* producer, stall, flush, cond_* query,
//   flags_arch, flags_pending. Macro FLAG_FWD_EN enables pend_f forwarding.
module nzcv_flag_pipe
  import arm_flags_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_set_flags,
  input  logic [WIDTH-1:0] ex_result,
  input  logic             ex_overflow,
  input  logic             ex_cout,
  input  logic             stall,
  input  logic             flush,
  input  logic             cond_valid,
  input  logic [3:0]       cond_code,
  output logic             cond_taken,
  output logic             cond_hold,
  output logic [3:0]       flags_arch,
  output logic             flags_pending
);

  nzcv_t ex_f;
  nzcv_t pend_f_q, pend_f_d;
  nzcv_t arch_q, arch_d;
  nzcv_t eval_f;
  logic  pend_v_q, pend_v_d;
  logic  producer;
  logic  raw_taken;
  logic  hold;

  assign producer = ex_valid && ex_set_flags;

  always_comb begin
    ex_f.N = ex_result[WIDTH-1];
    ex_f.Z = (ex_result == '0);
    ex_f.C = ex_cout;
    ex_f.V = ex_overflow;
  end

  // Flush kills both the pending entry and any producer now in EX,
  // and wins over stall.
  always_comb begin
    pend_v_d = pend_v_q;
    pend_f_d = pend_f_q;
    arch_d   = arch_q;
    if (flush) begin
      pend_v_d = 1'b0;
    end else if (!stall) begin
      if (pend_v_q) arch_d = pend_f_q;
      pend_v_d = producer;
      if (producer) pend_f_d = ex_f;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_v_q <= 1'b0;
      pend_f_q <= NZCV_RESET;
      arch_q   <= NZCV_RESET;
    end else begin
      pend_v_q <= pend_v_d;
      pend_f_q <= pend_f_d;
      arch_q   <= arch_d;
    end
  end

`ifdef FLAG_FWD_EN
  assign eval_f = pend_v_q ? pend_f_q : arch_q;
  assign hold   = cond_valid && producer;
`else
  // Without forwarding, wait until the pending entry has committed.
  assign eval_f = arch_q;
  assign hold   = cond_valid && (producer || pend_v_q);
`endif

  cond_eval u_cond_eval (
    .flags (eval_f),
    .code  (cond_e'(cond_code)),
    .taken (raw_taken)
  );

  assign cond_hold     = hold;
  assign cond_taken    = cond_valid && !hold && raw_taken;
  assign flags_arch    = arch_q;
  assign flags_pending = pend_v_q;

endmodule
